// File: rtl/selfcheck_seq_pkg.sv
// Shared definitions for the selfcheck_seq self-check sequencer: state encoding,
// default timing and the gate-window compare helper.
package selfcheck_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    EVAL  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam int DEFAULT_PHASE_LEN = 10000;
  localparam int DEFAULT_DEAD      = 1000;
  localparam int NUM_GATES         = 4;
  localparam int CNT_W             = 16;

  // Open-low / closed-high window: lo < data <= hi, unsigned 16-bit.
  function automatic logic in_window(input logic [CNT_W-1:0] data,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (data > lo) && (data <= hi);
  endfunction

endpackage

// File: rtl/selfcheck_seq_tick_div.sv
// TICK_DIV prescaler: registered one-clock tick enable every TICK_DIV clocks,
// restarting from zero whenever clr is high.
module selfcheck_seq_tick_div
  import selfcheck_seq_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
      tick    <= 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/selfcheck_seq.sv
// Self-check sequencer: walks check_data through four switch phases, drives one
// test gate per phase with dead bands at each end, and reports pass/abort.
module selfcheck_seq
  import selfcheck_seq_pkg::*;
#(
  parameter int PHASE_LEN = DEFAULT_PHASE_LEN,
  parameter int DEAD      = DEFAULT_DEAD,
  parameter int TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        check_req,
  input  logic        stop,
  input  logic        Lockn,
  input  logic        fault_in,
  output logic        check,
  output logic [15:0] check_data,
  output logic [3:0]  gate,
  output logic        pass,
  output logic        done,
  output logic        aborted
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(4 * PHASE_LEN);

  state_t               state_reg;
  logic                 tick;
  logic                 presc_clr;
  logic                 start_ok;
  logic                 abort_req;
  logic [CNT_W-1:0]     data_inc;
  logic [NUM_GATES-1:0] win_inc;
  logic [NUM_GATES-1:0] win_start;

  assign data_inc  = check_data + 16'd1;
  assign start_ok  = check_req && Lockn && !stop && !fault_in;
  assign abort_req = stop || !Lockn || fault_in;
  // Holding the prescaler clear outside RUN means it starts from zero on entry.
  assign presc_clr = (state_reg != RUN);

  // Gate windows are evaluated on the value check_data is about to take, so the
  // registered gate changes on the same edge as the counter.
  generate
    for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_win
      localparam logic [CNT_W-1:0] LO = CNT_W'(gi * PHASE_LEN + DEAD);
      localparam logic [CNT_W-1:0] HI = CNT_W'((gi + 1) * PHASE_LEN - DEAD);
      assign win_inc[gi]   = in_window(data_inc, LO, HI);
      assign win_start[gi] = in_window(16'd1, LO, HI);
    end
  endgenerate

  selfcheck_seq_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .clk (clk),
    .rst (rst),
    .clr (presc_clr),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      check      <= 1'b0;
      check_data <= '0;
      gate       <= '0;
      pass       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            state_reg  <= RUN;
            check      <= 1'b1;
            check_data <= 16'd1;
            gate       <= win_start;
            pass       <= 1'b0;
            aborted    <= 1'b0;
          end
        end
        RUN: begin
          // Abort wins over a coincident final tick.
          if (abort_req) begin
            state_reg  <= ABORT;
            check      <= 1'b0;
            check_data <= '0;
            gate       <= '0;
            pass       <= 1'b0;
            aborted    <= 1'b1;
          end else if (tick) begin
            check_data <= data_inc;
            if (data_inc == LAST_CNT) begin
              state_reg <= EVAL;
              gate      <= '0;
            end else begin
              gate <= win_inc;
            end
          end
        end
        EVAL: begin
          state_reg <= DONE;
          pass      <= !fault_in;
          check     <= 1'b0;
          done      <= 1'b1;
        end
        DONE: begin
          state_reg  <= IDLE;
          done       <= 1'b0;
          check_data <= '0;
        end
        ABORT: begin
          if (!check_req && !stop) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_selfcheck_seq.sv
// Scoreboard bench for selfcheck_seq: a default-parameter instance and a small
// fast instance run side by side; completion events and gate samples are queued.
module tb_selfcheck_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, req0, stop0, lockn0, fault0;
  logic rst1, req1, stop1, lockn1, fault1;

  logic        check_s   [2];
  logic [15:0] data_s    [2];
  logic [3:0]  gate_s    [2];
  logic        pass_s    [2];
  logic        done_s    [2];
  logic        aborted_s [2];

  selfcheck_seq dut0 (
    .clk(clk), .rst(rst0), .check_req(req0), .stop(stop0), .Lockn(lockn0), .fault_in(fault0),
    .check(check_s[0]), .check_data(data_s[0]), .gate(gate_s[0]), .pass(pass_s[0]),
    .done(done_s[0]), .aborted(aborted_s[0])
  );

  selfcheck_seq #(.PHASE_LEN(10), .DEAD(2), .TICK_DIV(4)) dut1 (
    .clk(clk), .rst(rst1), .check_req(req1), .stop(stop1), .Lockn(lockn1), .fault_in(fault1),
    .check(check_s[1]), .check_data(data_s[1]), .gate(gate_s[1]), .pass(pass_s[1]),
    .done(done_s[1]), .aborted(aborted_s[1])
  );

  typedef struct {
    int          dut;
    string       name;
    logic        is_done;
    logic        pass;
    logic        aborted;
    logic [15:0] data;
    int          cycles;   // check-high clocks for a done event, -1 = not checked
  } ev_t;

  typedef struct {
    int          dut;
    logic [15:0] data;
    logic [3:0]  gate;
  } gx_t;

  ev_t ev_q[$];
  gx_t gx_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int          check_cnt [2];
  int          done_cnt  [2];
  logic        aborted_d [2];
  logic        check_d   [2];
  logic [15:0] prev_data [2];
  logic [3:0]  prev_gate [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int d, input string name, input logic is_done, input logic p,
                         input logic ab, input logic [15:0] data, input int cycles);
    ev_t e;
    e.dut = d; e.name = name; e.is_done = is_done; e.pass = p;
    e.aborted = ab; e.data = data; e.cycles = cycles;
    ev_q.push_back(e);
  endtask

  task automatic push_gx(input int d, input logic [15:0] data, input logic [3:0] g);
    gx_t x;
    x.dut = d; x.data = data; x.gate = g;
    gx_q.push_back(x);
  endtask

  task automatic mon_step(input int d);
    int idx;
    ev_t e;
    if (check_s[d] === 1'b1) check_cnt[d] = (check_d[d] === 1'b1) ? check_cnt[d] + 1 : 1;
    if (done_s[d] === 1'b1) done_cnt[d]++;

    if (gate_s[d] !== prev_gate[d]) begin
      n_checks++;
      if ($countones(gate_s[d]) > 1) begin
        n_fail++;
        $display("FAIL dut%0d gate onehot: got %b, required at most one bit", d, gate_s[d]);
      end
    end

    if (data_s[d] !== prev_data[d]) begin
      idx = -1;
      for (int i = 0; i < gx_q.size(); i++) if (gx_q[i].dut == d) begin idx = i; break; end
      if (idx >= 0 && gx_q[idx].data == data_s[d]) begin
        chk($sformatf("dut%0d gate@%0d", d, data_s[d]), 32'(gate_s[d]), 32'(gx_q[idx].gate));
        gx_q.delete(idx);
      end
    end

    if (done_s[d] === 1'b1 || (aborted_s[d] === 1'b1 && aborted_d[d] !== 1'b1)) begin
      $display("dut%0d event: done=%0b pass=%0b aborted=%0b data=%0d gate=%b check_clocks=%0d",
               d, done_s[d], pass_s[d], aborted_s[d], data_s[d], gate_s[d], check_cnt[d]);
      idx = -1;
      for (int i = 0; i < ev_q.size(); i++) if (ev_q[i].dut == d) begin idx = i; break; end
      if (idx < 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut%0d unexpected event: done=%0b aborted=%0b, required none", d, done_s[d], aborted_s[d]);
      end else begin
        e = ev_q[idx];
        ev_q.delete(idx);
        chk({e.name, " done"},    32'(done_s[d]),    32'(e.is_done));
        chk({e.name, " pass"},    32'(pass_s[d]),    32'(e.pass));
        chk({e.name, " aborted"}, 32'(aborted_s[d]), 32'(e.aborted));
        chk({e.name, " data"},    32'(data_s[d]),    32'(e.data));
        chk({e.name, " gate"},    32'(gate_s[d]),    32'd0);
        if (e.cycles >= 0) chk({e.name, " check clocks"}, 32'(check_cnt[d]), 32'(e.cycles));
      end
    end

    aborted_d[d] = aborted_s[d];
    check_d[d]   = check_s[d];
    prev_data[d] = data_s[d];
    prev_gate[d] = gate_s[d];
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  task automatic wait_data(input int d, input logic [15:0] v, input int budget);
    int n = 0;
    while (data_s[d] !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (data_s[d] !== v) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d wait check_data: got %0d after %0d clocks, required %0d", d, data_s[d], n, v);
    end
  endtask

  task automatic wait_done(input int d, input int budget);
    int n = 0;
    while (done_s[d] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_s[d] !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d wait done: got %b after %0d clocks, required 1", d, done_s[d], n);
    end
  endtask

  task automatic run0();
    rst0 = 1'b1; req0 = 1'b0; stop0 = 1'b0; lockn0 = 1'b1; fault0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst check",      32'(check_s[0]),   0);
    chk("rst check_data", 32'(data_s[0]),    0);
    chk("rst gate",       32'(gate_s[0]),    0);
    chk("rst pass",       32'(pass_s[0]),    0);
    chk("rst done",       32'(done_s[0]),    0);
    chk("rst aborted",    32'(aborted_s[0]), 0);
    rst0 = 1'b0;

    // Locked interlock must keep the request from starting.
    lockn0 = 1'b0; req0 = 1'b1;
    repeat (5) @(negedge clk);
    chk("locked check",      32'(check_s[0]), 0);
    chk("locked check_data", 32'(data_s[0]),  0);
    req0 = 1'b0; lockn0 = 1'b1;
    @(negedge clk);

    // Full default run.
    push_gx(0, 16'd1000, 4'b0000);  push_gx(0, 16'd1001, 4'b0001);
    push_gx(0, 16'd5000, 4'b0001);  push_gx(0, 16'd9000, 4'b0001);
    push_gx(0, 16'd9001, 4'b0000);  push_gx(0, 16'd10000, 4'b0000);
    push_gx(0, 16'd15000, 4'b0010); push_gx(0, 16'd25000, 4'b0100);
    push_gx(0, 16'd31001, 4'b1000); push_gx(0, 16'd35000, 4'b1000);
    push_gx(0, 16'd39000, 4'b1000); push_gx(0, 16'd40000, 4'b0000);
    push_ev(0, "dut0 full run", 1'b1, 1'b1, 1'b0, 16'd40000, 40001);
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    chk("start check_data", 32'(data_s[0]),  1);
    chk("start check",      32'(check_s[0]), 1);
    wait_done(0, 41000);
    @(negedge clk);
    chk("after done check_data", 32'(data_s[0]),  0);
    chk("after done pass",       32'(pass_s[0]),  1);
    chk("after done done",       32'(done_s[0]),  0);

    // Fault during phase 2.
    push_gx(0, 16'd15000, 4'b0010);
    push_ev(0, "dut0 fault abort", 1'b0, 1'b0, 1'b1, 16'd0, -1);
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    wait_data(0, 16'd15000, 16000);
    fault0 = 1'b1;
    @(negedge clk);
    chk("fault check", 32'(check_s[0]), 0);
    fault0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("fault aborted held", 32'(aborted_s[0]), 1);
    chk("fault pass held",    32'(pass_s[0]),    0);

    // Interlock drop mid-run; ABORT must hold while check_req stays high.
    push_ev(0, "dut0 interlock abort", 1'b0, 1'b0, 1'b1, 16'd0, -1);
    req0 = 1'b1;
    @(negedge clk);
    wait_data(0, 16'd200, 400);
    lockn0 = 1'b0;
    @(negedge clk);
    lockn0 = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort holds with check_req", 32'(check_s[0]), 0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("interlock aborted held", 32'(aborted_s[0]), 1);

    // Reset in the middle of phase 3, then restart and stop.
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    wait_data(0, 16'd22222, 23000);
    chk("pre-reset gate", 32'(gate_s[0]), 32'b0100);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    chk("midrun rst check",      32'(check_s[0]),   0);
    chk("midrun rst check_data", 32'(data_s[0]),    0);
    chk("midrun rst gate",       32'(gate_s[0]),    0);
    chk("midrun rst aborted",    32'(aborted_s[0]), 0);
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    chk("restart check_data", 32'(data_s[0]), 1);
    wait_data(0, 16'd5, 50);
    push_ev(0, "dut0 stop abort", 1'b0, 1'b0, 1'b1, 16'd0, -1);
    stop0 = 1'b1;
    @(negedge clk);
    stop0 = 1'b0;
    chk("stop check", 32'(check_s[0]), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run1();
    int n;
    rst1 = 1'b1; req1 = 1'b0; stop1 = 1'b0; lockn1 = 1'b1; fault1 = 1'b0;
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    push_gx(1, 16'd2, 4'b0000);  push_gx(1, 16'd3, 4'b0001);
    push_gx(1, 16'd8, 4'b0001);  push_gx(1, 16'd9, 4'b0000);
    push_gx(1, 16'd13, 4'b0010); push_gx(1, 16'd38, 4'b1000);
    push_gx(1, 16'd39, 4'b0000); push_gx(1, 16'd40, 4'b0000);
    push_ev(1, "dut1 full run", 1'b1, 1'b1, 1'b0, 16'd40, 158);
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    wait_data(1, 16'd10, 100);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (data_s[1] !== 16'd11 && n < 20);
    chk("dut1 tick spacing", 32'(n), 4);
    wait_done(1, 300);
    @(negedge clk);
    chk("dut1 after done check_data", 32'(data_s[1]), 0);
    chk("dut1 after done pass",       32'(pass_s[1]), 1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      check_cnt[d] = 0; done_cnt[d] = 0; aborted_d[d] = 1'b0; check_d[d] = 1'b0;
      prev_data[d] = '0; prev_gate[d] = '0;
    end
    fork
      run0();
      run1();
    join
    repeat (2) @(negedge clk);
    chk("event queue drained", 32'(ev_q.size()), 0);
    chk("gate queue drained",  32'(gx_q.size()), 0);
    chk("dut0 done pulses",    32'(done_cnt[0]), 1);
    chk("dut1 done pulses",    32'(done_cnt[1]), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
